burst_memory_responder: RTL and testbench
=========================================

# burst_memory_responder

Physical-memory end of the cache-line burst protocol: sits below the cache-line adaptor and answers its 64-bit, 4-beat read and write bursts from an internal line-organised backing store. It is the responder counterpart to the adaptor's initiator side. It is used as the synthesizable main-memory model for the two-cache + arbiter + adaptor memory subsystem, with a programmable access latency.

## Interface
- LINE_IDX_BITS, default 8: number of line-index bits. The store holds 2^LINE_IDX_BITS lines of 256 bits.
- LATENCY, default 4: wait cycles between accepting a request and the first beat. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address_i  in  32  line address from the adaptor. Bits [4:0] are ignored. Index = address_i[LINE_IDX_BITS+4:5]. Higher bits are ignored, so addresses alias.
- read_i  in  1  read request; held high until the burst completes.
- write_i  in  1  write request; held high until the burst completes.
- burst_i  in  64  write beat data from the adaptor.
- burst_o  out  64  read beat data to the adaptor.
- resp_o  out  1  beat-valid; high for exactly 4 consecutive cycles per transfer.
- error_o  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, WAIT, BURST, DONE.
- IDLE:
  - On an edge where read_i or write_i is high, latch the index and direction, load the countdown with LATENCY, and go to WAIT.
  - If read_i and write_i are both high, the read wins and error_o is set.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where the counter reaches 0, go to BURST with beat counter = 0.
  - For a read, the addressed line is copied into a 256-bit line buffer on that same edge.
- BURST, read:
  - resp_o = 1 and burst_o = line_buf[64*beat +: 64].
  - Beat 0 is bits [63:0], in ascending order.
- BURST, write:
  - resp_o = 1. The edge ending each beat samples burst_i into line_buf[64*beat +: 64].
  - The edge ending beat 3 commits line_buf to the store.
- BURST advances beat each edge. After beat 3 it goes to DONE.
- DONE: resp_o = 0 for one cycle, then return to IDLE. The adaptor drops its request during this cycle. A request still high on the IDLE edge that follows is treated as a new request.
- Abort: if the latched direction's request drops while in WAIT or BURST:
  - go to IDLE next edge and set error_o;
  - nothing is committed, so the store is unchanged.
- error_o clears only on reset.
- Store contents are not reset. Only control state is reset.
- Counters:
  - The countdown is 4 bits.
  - The beat counter is 2 bits and wraps 3->0 only at the BURST exit.
  - No arithmetic is done on address bits.

## Timing
- All outputs are registered.
- Reset values: resp_o = 0, burst_o = 64'h0, error_o = 0, state = IDLE, counters = 0.
- burst_o is 64'h0 in every cycle that is not a read beat, including write beats.
- Cycle numbering: a request is first high in cycle 0 and accepted at edge 0. Cycle n is the cycle following edge n-1.
  - WAIT occupies cycles 1..L.
  - resp_o is high in cycles L+1..L+4.
  - DONE is cycle L+5.
  - IDLE is cycle L+6; the earliest next acceptance is at edge L+6.
- A read returns L+4 cycles after acceptance and costs L+6 cycles total per transfer.
- Write-then-read to the same index: the commit at the edge ending beat 3 is visible to the next read, because the read's line copy happens at least L edges later.
- Asynchronous reset mid-WAIT or mid-BURST:
  - outputs go to reset values immediately;
  - a partial write is discarded;
  - after release, the block is in IDLE with the request re-sampled on the first edge.
- The value of address_i after acceptance is don't-care.

## Test plan
- Reset: hold reset_n = 0 with read_i = 1 -> resp_o = 0, burst_o = 0, error_o = 0. Release -> request accepted on the first edge, first beat 5 cycles later (L = 4).
- Write then read:
  - Write 0x0000_0140 with beats 64'hA0, A1, A2, A3 -> resp_o high cycles 5..8, one low cycle, error_o = 0.
  - Read 0x0000_015C (same line, offset ignored) -> burst_o = A0, A1, A2, A3 in cycles 5..8 after acceptance.
- Aliasing: write to 0x0000_2140 (index 0x0A, bits above 12 ignored), then read 0x0000_0140 -> the newly written data is returned.
- Latency sweep: LATENCY = 1 and LATENCY = 15 -> first resp_o in cycle 2 and cycle 16 respectively; exactly 4 resp_o cycles each.
- Back-to-back: read_i held high across DONE -> second read accepted at edge L+6, first beat in cycle 2L+7.
- Errors:
  - read_i = write_i = 1 -> read performed, error_o = 1.
  - Drop write_i after beat 1 -> return to IDLE, error_o = 1, and a later read of that line returns the old data.
  - Assert reset_n = 0 mid-burst -> resp_o drops immediately and no commit occurs.

Source files
------------

// File: rtl/burst_memory_responder.sv
`default_nettype none
// ============================================================================
// burst_memory_responder
// Line-organised backing store answering 4-beat, 64-bit read/write bursts.
// Revision: 1.0
// ============================================================================
module burst_memory_responder #(
    parameter int LINE_IDX_BITS = 8,
    parameter int LATENCY       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address_i,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [63:0] burst_i,
    output logic [63:0] burst_o,
    output logic        resp_o,
    output logic        error_o
);
    localparam int         LINES = 1 << LINE_IDX_BITS;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state;
    logic [LINE_IDX_BITS-1:0] idx;
    logic                     is_read;
    logic [3:0]               cnt;
    logic [1:0]               beat;
    logic [255:0]             line_buf;
    logic [255:0]             store [LINES];

    logic [LINE_IDX_BITS-1:0] req_idx;
    logic                     req_live;
    logic                     commit;
    logic [1:0]               next_beat;
    logic                     unused_addr;

    assign req_idx     = address_i[LINE_IDX_BITS+4:5];
    assign req_live    = is_read ? read_i : write_i;
    assign next_beat   = beat + 2'd1;
    assign unused_addr = ^{address_i[31:LINE_IDX_BITS+5], address_i[4:0]};

    // The last beat is merged straight from burst_i so the commit lands on the edge ending beat 3.
    assign commit = (state == BURST) && !is_read && (beat == 2'd3) && write_i;

    always_ff @(posedge clk) begin
        if (commit) begin
            store[idx] <= {burst_i, line_buf[191:0]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            is_read  <= 1'b0;
            cnt      <= 4'd0;
            beat     <= 2'd0;
            line_buf <= '0;
            resp_o   <= 1'b0;
            burst_o  <= 64'h0;
            error_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_i || write_i) begin
                        idx     <= req_idx;
                        is_read <= read_i;
                        cnt     <= LAT;
                        state   <= WAIT;
                        if (read_i && write_i) begin
                            error_o <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!req_live) begin
                        state   <= IDLE;
                        cnt     <= 4'd0;
                        error_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state  <= BURST;
                            beat   <= 2'd0;
                            resp_o <= 1'b1;
                            if (is_read) begin
                                line_buf <= store[idx];
                                burst_o  <= store[idx][63:0];
                            end
                        end
                    end
                end
                BURST: begin
                    if (!req_live) begin
                        state   <= IDLE;
                        beat    <= 2'd0;
                        resp_o  <= 1'b0;
                        burst_o <= 64'h0;
                        error_o <= 1'b1;
                    end else begin
                        if (!is_read) begin
                            line_buf[{beat, 6'd0} +: 64] <= burst_i;
                        end
                        beat <= next_beat;
                        if (beat == 2'd3) begin
                            state   <= DONE;
                            resp_o  <= 1'b0;
                            burst_o <= 64'h0;
                        end else if (is_read) begin
                            burst_o <= line_buf[{next_beat, 6'd0} +: 64];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_burst_memory_responder.sv
`default_nettype none
// ============================================================================
// tb_burst_memory_responder
// Scoreboard bench for the burst memory responder.
// Revision: 1.0
// ============================================================================
module tb_burst_memory_responder;
    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] address_i;
    logic        read_i;
    logic        write_i;
    logic [63:0] burst_i;
    logic [63:0] burst_o;
    logic        resp_o;
    logic        error_o;

    logic        rd1, rd15;
    logic        wr_off = 1'b0;
    logic [63:0] bo1, bo15;
    logic        resp1, resp15, err1, err15;

    int          checks = 0;
    int          errors = 0;
    logic        exp_err;
    logic [63:0] exp_q[$];
    logic [255:0] model [256];

    always #5 clk = ~clk;

    burst_memory_responder #(.LINE_IDX_BITS(8), .LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
        .write_i(write_i), .burst_i(burst_i), .burst_o(burst_o), .resp_o(resp_o),
        .error_o(error_o)
    );

    burst_memory_responder #(.LINE_IDX_BITS(8), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(rd1),
        .write_i(wr_off), .burst_i(burst_i), .burst_o(bo1), .resp_o(resp1),
        .error_o(err1)
    );

    burst_memory_responder #(.LINE_IDX_BITS(8), .LATENCY(15)) dut_l15 (
        .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(rd15),
        .write_i(wr_off), .burst_i(burst_i), .burst_o(bo15), .resp_o(resp15),
        .error_o(err15)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the cycle the task is entered in; returns in the IDLE cycle L+6.
    task automatic do_read(input logic [31:0] addr, input bit hold, input bit chk_data,
                           input bit both);
        address_i = addr;
        read_i    = 1'b1;
        write_i   = both;
        if (both) exp_err = 1'b1;
        if (chk_data)
            for (int b = 0; b < 4; b++) exp_q.push_back(model[addr[12:5]][64*b +: 64]);
        for (int n = 1; n <= L + 5; n++) begin
            tick();
            check("rd_resp", resp_o, (n >= L + 1) && (n <= L + 4));
            if (resp_o && chk_data && exp_q.size() > 0)
                check("rd_data", burst_o, exp_q.pop_front());
            else if (!resp_o)
                check("rd_idle_data", burst_o, 64'h0);
            if (n == L + 5) begin
                if (!hold) read_i = 1'b0;
                write_i = 1'b0;
            end
        end
        check("rd_q_empty", exp_q.size(), 64'd0);
        exp_q.delete();
        check("rd_err", error_o, exp_err);
        tick();
    endtask

    // abort_after < 3 drops write_i once that beat has been delivered.
    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int abort_after);
        int k;
        bit ab;
        k  = abort_after;
        ab = (abort_after < 4);
        address_i = addr;
        write_i   = 1'b1;
        burst_i   = 64'h0;
        for (int n = 1; n <= L + 5; n++) begin
            tick();
            check("wr_resp", resp_o, (n >= L + 1) && (n <= L + 4) && !(ab && n >= L + 3 + k));
            check("wr_data", burst_o, 64'h0);
            if (ab && n == L + 3 + k) begin
                check("wr_abort_err", error_o, 64'd1);
                exp_err = 1'b1;
                break;
            end
            if (n >= L + 1 && n <= L + 4) burst_i = line[64*(n-L-1) +: 64];
            if ((ab && n == L + 2 + k) || n == L + 5) write_i = 1'b0;
        end
        write_i = 1'b0;
        if (!ab) model[addr[12:5]] = line;
        check("wr_err", error_o, exp_err);
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        exp_err = 1'b0;
    endtask

    task automatic latency_sweep();
        int c1, c15;
        c1  = 0;
        c15 = 0;
        address_i = 32'h0;
        rd1  = 1'b1;
        rd15 = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            tick();
            check("l1_resp", resp1, (n >= 2) && (n <= 5));
            check("l15_resp", resp15, (n >= 16) && (n <= 19));
            if (!resp1) check("l1_idle_data", bo1, 64'h0);
            if (!resp15) check("l15_idle_data", bo15, 64'h0);
            c1  += int'(resp1);
            c15 += int'(resp15);
            if (n == 6) rd1 = 1'b0;
            if (n == 20) rd15 = 1'b0;
        end
        check("l1_count", c1, 64'd4);
        check("l15_count", c15, 64'd4);
        check("l1_err", err1, 64'd0);
        check("l15_err", err15, 64'd0);
    endtask

    initial begin
        logic [255:0] line_a, line_b, line_c, line_d, line_e, line_f;
        line_a = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        line_b = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
                  64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
        line_c = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        line_d = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        line_e = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
                  64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
        line_f = {64'hF3, 64'hF2, 64'hF1, 64'hF0};
        for (int i = 0; i < 256; i++) model[i] = '0;
        exp_err   = 1'b0;
        reset_n   = 1'b0;
        read_i    = 1'b1;
        write_i   = 1'b0;
        address_i = 32'h0000_0140;
        burst_i   = 64'h0;
        rd1       = 1'b0;
        rd15      = 1'b0;

        repeat (3) tick();
        check("rst_resp", resp_o, 64'd0);
        check("rst_data", burst_o, 64'h0);
        check("rst_err", error_o, 64'd0);
        reset_n = 1'b1;
        do_read(32'h0000_0140, 1'b0, 1'b0, 1'b0);

        do_write(32'h0000_0140, line_a, 4);
        do_read(32'h0000_015C, 1'b0, 1'b1, 1'b0);

        do_write(32'h0000_2140, line_b, 4);
        do_read(32'h0000_0140, 1'b0, 1'b1, 1'b0);

        do_read(32'h0000_0140, 1'b1, 1'b1, 1'b0);
        do_read(32'h0000_0140, 1'b0, 1'b1, 1'b0);

        latency_sweep();

        do_read(32'h0000_0140, 1'b0, 1'b1, 1'b1);

        do_reset();
        check("post_rst_err", error_o, 64'd0);
        do_write(32'h0000_0300, line_c, 4);
        do_write(32'h0000_0300, line_d, 1);
        do_read(32'h0000_0300, 1'b0, 1'b1, 1'b0);

        do_reset();
        do_write(32'h0000_0400, line_e, 4);
        address_i = 32'h0000_0400;
        write_i   = 1'b1;
        for (int n = 1; n <= L + 3; n++) begin
            tick();
            if (n >= L + 1) burst_i = line_f[64*(n-L-1) +: 64];
        end
        check("arst_pre_resp", resp_o, 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst_resp", resp_o, 64'd0);
        check("arst_data", burst_o, 64'h0);
        check("arst_err", error_o, 64'd0);
        write_i = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        do_read(32'h0000_0400, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
